// File: rtl/_ser_tx_pkg.sv
// rtl/_ser_tx_pkg.sv - types and constants for the serial transmitter
//
// Purpose: wraps the shared serial definitions and provides the FSM state enum
// built on those encodings.
package _ser_tx_pkg;

  `include "ser_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE  = SER_ST_IDLE,
    ST_START = SER_ST_START,
    ST_DATA  = SER_ST_DATA,
    ST_STOP  = SER_ST_STOP
  } state_e;

endpackage

// File: rtl/_baud_cnt.sv
// rtl/_baud_cnt.sv - bit-period counter producing bit-boundary ticks
//
// Purpose: counts 0..BAUD_DIV-1 while enabled and wraps to 0; held at 0 when
// disabled so every frame starts on a fresh bit period.
// Ports:
//   clk     - clock, rising edge
//   reset_n - synchronous active-low reset
//   en      - count enable (high while a frame is in flight)
//   tick    - high in the last cycle of each bit period
module _baud_cnt #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/ser_defs.vh
// rtl/ser_defs.vh - shared serial-link constants (state encodings, payload width)
//
// Included inside a package scope; the serial TX and a future serial RX share
// these encodings so that debug views and captured traces decode identically.
localparam logic [1:0] SER_ST_IDLE  = 2'b00;
localparam logic [1:0] SER_ST_START = 2'b01;
localparam logic [1:0] SER_ST_DATA  = 2'b10;
localparam logic [1:0] SER_ST_STOP  = 2'b11;

localparam int SER_DATA_W = 8;

// File: rtl/_ser_tx.sv
// rtl/_ser_tx.sv - serial transmitter: start bit, 8 data bits LSB first, stop bit
//
// Purpose: accepts a byte on a valid/ready handshake and shifts it out on tx,
// each bit lasting BAUD_DIV clock cycles.
// Ports:
//   clk     - clock, rising edge
//   reset_n - synchronous active-low reset
//   valid   - send request, accepted when ready is high
//   data    - payload, sampled only on the accept edge
//   ready   - high while idle
//   tx      - registered serial line, idles high
//   busy    - high while a frame is on the line
//   done    - one-cycle pulse in the first idle cycle after a completed frame
module _ser_tx
  import _ser_tx_pkg::*;
#(
  parameter int BAUD_DIV = 4,
  parameter int DATA_W   = SER_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;
  logic              baud_en;

  assign baud_en = (state_q != ST_IDLE);

  _baud_cnt #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (baud_en),
    .tick   (tick)
  );

  // tx is updated one edge ahead of each bit period so the line is always
  // driven straight from tx_q with no path from valid/data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            state_q <= ST_START;
            shreg_q <= data;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state_q <= ST_DATA;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_q == LAST_IDX) begin
              state_q   <= ST_STOP;
              tx_q      <= 1'b1;
              bit_idx_q <= '0;
            end else begin
              tx_q      <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb__ser_tx.sv
// tb/tb__ser_tx.sv - self-checking bench for the serial transmitter
module tb__ser_tx;

  logic       clk;
  logic       reset_n;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  logic       valid2;
  logic [7:0] data2;
  logic       ready2;
  logic       tx2;
  logic       busy2;
  logic       done2;

  int n_vec;
  int n_bad;

  _ser_tx #(.BAUD_DIV(4), .DATA_W(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .valid  (valid),
    .data   (data),
    .ready  (ready),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  _ser_tx #(.BAUD_DIV(2), .DATA_W(8)) dut2 (
    .clk    (clk),
    .reset_n(reset_n),
    .valid  (valid2),
    .data   (data2),
    .ready  (ready2),
    .tx     (tx2),
    .busy   (busy2),
    .done   (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seq[9] is the first bit on the line (start), seq[0] the stop bit
  typedef struct {
    logic [7:0] d;
    logic [9:0] seq;
    bit         noise;
    bit         chain;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [9:0] seq, input bit noise,
                           input bit chained_in, input bit chain_out, input logic [7:0] next_d);
    if (!chained_in) begin
      @(negedge clk);
      chk($sformatf("ready_before_%02h", d), 32'(ready), 32'd1);
      valid = 1'b1;
      data  = d;
      @(negedge clk);
    end
    if (noise) begin
      valid = 1'b1;
      data  = 8'hFF;
    end else begin
      valid = 1'b0;
      data  = 8'h00;
    end
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("tx_%02h_c%0d", d, c), 32'(tx), 32'(seq[9 - c / 4]));
      chk($sformatf("busy_%02h_c%0d", d, c), 32'(busy), 32'd1);
      chk($sformatf("done_early_%02h_c%0d", d, c), 32'(done), 32'd0);
      @(negedge clk);
    end
    chk($sformatf("done_pulse_%02h", d), 32'(done), 32'd1);
    chk($sformatf("busy_end_%02h", d), 32'(busy), 32'd0);
    chk($sformatf("tx_gap_%02h", d), 32'(tx), 32'd1);
    chk($sformatf("ready_end_%02h", d), 32'(ready), 32'd1);
    if (chain_out) begin
      valid = 1'b1;
      data  = next_d;
      @(negedge clk);
    end else begin
      valid = 1'b0;
      @(negedge clk);
      chk($sformatf("done_once_%02h", d), 32'(done), 32'd0);
      chk($sformatf("tx_idle_%02h", d), 32'(tx), 32'd1);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    vecs[0] = '{d: 8'hA5, seq: 10'b0101001011, noise: 1'b0, chain: 1'b0};
    vecs[1] = '{d: 8'h3C, seq: 10'b0001111001, noise: 1'b1, chain: 1'b1};
    vecs[2] = '{d: 8'hFF, seq: 10'b0111111111, noise: 1'b0, chain: 1'b0};
    vecs[3] = '{d: 8'h00, seq: 10'b0000000001, noise: 1'b1, chain: 1'b1};
    vecs[4] = '{d: 8'hFF, seq: 10'b0111111111, noise: 1'b0, chain: 1'b0};

    // reset held two cycles with valid asserted
    reset_n = 1'b0;
    valid   = 1'b1;
    data    = 8'hA5;
    valid2  = 1'b1;
    data2   = 8'h01;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    valid   = 1'b0;
    valid2  = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(ready), 32'd1);
    chk("rel_ready2", 32'(ready2), 32'd1);
    for (int c = 0; c < 10; c++) begin
      chk("rel_no_frame_tx", 32'(tx), 32'd1);
      chk("rel_no_frame_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // table of frames: single, busy-ignore, back-to-back
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].d, vecs[i].seq, vecs[i].noise,
                (i > 0) && vecs[i - 1].chain, vecs[i].chain,
                (i < 4) ? vecs[(i < 4) ? i + 1 : i].d : 8'h00);
    end

    // reset during data bit 3 of 8'h55
    @(negedge clk);
    valid = 1'b1;
    data  = 8'h55;
    @(negedge clk);
    valid = 1'b0;
    for (int c = 0; c < 17; c++) begin
      chk($sformatf("tx_55_c%0d", c), 32'(tx), 32'(((c / 4) % 2 == 1) ? 1 : 0));
      @(negedge clk);
    end
    chk("tx_55_bit3", 32'(tx), 32'd0);
    chk("busy_55_bit3", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    reset_n = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
      chk("midrst_tx_idle", 32'(tx), 32'd1);
    end
    run_frame(8'h81, 10'b0100000011, 1'b0, 1'b0, 1'b0, 8'h00);

    // minimum divider on the second instance
    @(negedge clk);
    chk("div2_ready", 32'(ready2), 32'd1);
    valid2 = 1'b1;
    data2  = 8'h01;
    @(negedge clk);
    valid2 = 1'b0;
    begin
      logic [9:0] seq01;
      seq01 = 10'b0100000001;
      for (int c = 0; c < 20; c++) begin
        chk($sformatf("div2_tx_c%0d", c), 32'(tx2), 32'(seq01[9 - c / 2]));
        chk($sformatf("div2_busy_c%0d", c), 32'(busy2), 32'd1);
        chk($sformatf("div2_done_c%0d", c), 32'(done2), 32'd0);
        @(negedge clk);
      end
    end
    chk("div2_done", 32'(done2), 32'd1);
    chk("div2_busy_end", 32'(busy2), 32'd0);
    chk("div2_tx_end", 32'(tx2), 32'd1);
    @(negedge clk);
    chk("div2_done_once", 32'(done2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/_ser_tx.md
_SER_TX -- requirements
Module: _ser_tx

Interface
REQ-001 Parameter: BAUD_DIV, 4, clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter: DATA_W, 8, payload bits per frame; fixed at 8 for this revision.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 valid  input  1  request to send data; qualified by ready.
REQ-006 data  input  8  payload; sampled only on the accept edge.
REQ-007 ready  output  1  high while IDLE; a frame is accepted on an edge where valid=1 and ready=1.
REQ-008 tx  output  1  serial line, registered; idle level 1.
REQ-009 busy  output  1  high in START, DATA and STOP.
REQ-010 done  output  1  one-cycle pulse marking normal frame completion.

Function
REQ-011 Frame format: start bit 0, then 8 data bits LSB first, then stop bit 1; each bit lasts exactly BAUD_DIV cycles.
REQ-012 FSM states: IDLE, START, DATA, STOP; ready is decoded from state (IDLE).
REQ-013 Transition IDLE->START: on an accept edge, data is loaded into an internal shift register and tx goes 0 from the next cycle.
REQ-014 Transition START->DATA: after BAUD_DIV cycles; tx=data[0].
REQ-015 DATA: shift right and present the next bit every BAUD_DIV cycles; the 3-bit bit index wraps 7->0 on the transition to STOP.
REQ-016 Transition STOP->IDLE: after BAUD_DIV cycles of tx=1; done=1 in the first IDLE cycle only.
REQ-017 Latency: accept edge to first tx=0 cycle is 1 cycle; frame occupies exactly 10*BAUD_DIV cycles with busy=1.
REQ-018 When valid=1 while busy=1, the block shall ignore it; changes on data during a frame do not affect tx.
REQ-019 Back-to-back operation: when valid=1 during the done cycle, the block shall accept it on that edge, so the next start bit follows the stop bit with one idle-high cycle between.
REQ-020 Baud counter: counts 0..BAUD_DIV-1 and wraps to 0 at each bit boundary; the count is held at 0 in IDLE.
REQ-021 The tx output shall not glitch: it is driven directly from a flop, with no combinational path from valid or data.

Reset
REQ-022 On an edge with reset_n=0, the block shall set state=IDLE, tx=1, busy=0, done=0, baud counter=0, bit index=0 and shift register=0.
REQ-023 ready=1 from the first cycle after reset release.
REQ-024 Reset mid-frame abandons the frame: tx=1 on the next edge, and no done pulse is generated.
REQ-025 When valid=1 on the same edge as reset_n=0, the block shall not accept a frame.

Structure
REQ-026 The state encodings (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11) and the DATA_W constant shall live in shared include file ser_defs.vh, which a future _ser_rx also uses.
REQ-027 Sub-module _baud_cnt (parameter BAUD_DIV; ports clk, reset_n, en, tick) shall generate bit-boundary ticks; all other logic stays in _ser_tx.

Verification
REQ-028 Scenario, reset: hold reset_n=0 for 2 cycles with valid=1 -> tx=1, busy=0, done=0, ready=1 after release, no frame sent.
REQ-029 Scenario, single frame: BAUD_DIV=4, data=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy=1 for 40 cycles; done pulses once.
REQ-030 Scenario, busy: valid=1 with data=8'hFF throughout frame 8'h3C -> only 8'h3C is transmitted, and the next frame starts only after done.
REQ-031 Scenario, back-to-back: 8'h00 then 8'hFF with valid held -> the second start bit begins 1 cycle after the first stop bit ends; both frames are correct.
REQ-032 Scenario, reset mid-frame: reset_n=0 during data bit 3 of 8'h55 -> tx=1 on the next edge, no done, and a fresh frame 8'h81 afterwards is correct.
REQ-033 Scenario, minimum divider: BAUD_DIV=2, data=8'h01 -> frame length 20 cycles, with tx=1 only during data bit 0 and the stop bit.
